// File: rtl/rgb_palette_lut.sv
// Colour palette LUT: maps a pixel index to RGB through a writable palette,
// with per-index blink substitution, per-pixel dimming and blank-time palette writes.
module rgb_palette_lut #(
   parameter int IDX_W        = 4,
   parameter int COLOR_W      = 8,
   parameter int BLINK_FRAMES = 15,
   parameter int BLINK_IDX    = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [IDX_W-1:0]       i_data,
   input  logic                   i_valid,
   input  logic                   i_dim,
   input  logic                   i_frame_start,
   input  logic [2**IDX_W-1:0]    i_blink_mask,
   input  logic                   i_wr_en,
   input  logic [IDX_W-1:0]       i_wr_idx,
   input  logic [3*COLOR_W-1:0]   i_wr_rgb,
   output logic                   o_wr_busy,
   output logic [COLOR_W-1:0]     o_VGA_R,
   output logic [COLOR_W-1:0]     o_VGA_G,
   output logic [COLOR_W-1:0]     o_VGA_B,
   output logic                   o_valid
);

   localparam int DEPTH = 2**IDX_W;
   localparam int RGB_W = 3*COLOR_W;
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam longint unsigned MAXL = (64'd1 << COLOR_W) - 64'd1;
   localparam logic [COLOR_W-1:0] CMAX  = COLOR_W'(MAXL);
   localparam logic [COLOR_W-1:0] CZERO = '0;
   localparam logic [COLOR_W-1:0] C80   = COLOR_W'((MAXL * 64'd4) / 64'd5);
   localparam logic [COLOR_W-1:0] C31   = COLOR_W'((MAXL * 64'd31) / 64'd100);

   typedef enum logic {WR_IDLE, WR_PEND} wrState_t;

   function automatic logic [RGB_W-1:0] defaultColour(input int k);
      case (k)
         0:       return {CZERO, CZERO, CZERO};
         1:       return {CZERO, CZERO, CMAX};
         2:       return {CMAX,  CMAX,  CMAX};
         3:       return {CMAX,  CMAX,  CZERO};
         4:       return {CMAX,  CZERO, CZERO};
         5:       return {CMAX,  C80,   CMAX};
         6:       return {C31,   CMAX,  CMAX};
         7:       return {CMAX,  C80,   CZERO};
         default: return {CMAX,  CMAX,  CMAX};
      endcase
   endfunction

   logic [RGB_W-1:0]   pal_q [DEPTH];
   wrState_t           wrState_q, wrState_d;
   logic               commit;
   logic [IDX_W-1:0]   wrIdx_q;
   logic [RGB_W-1:0]   wrRgb_q;
   logic [CNT_W-1:0]   frameCnt_q;
   logic               phase_q;

   logic               s1Valid_q, s1Dim_q, s1Blink_q;
   logic [RGB_W-1:0]   s1Col_q, s1Alt_q;
   logic [RGB_W-1:0]   s2Sel;
   logic [COLOR_W-1:0] rDim, gDim, bDim;
   logic [COLOR_W-1:0] r_q, g_q, b_q;
   logic               valid_q;

   // Write buffer holds one request and commits only on a non-active-video cycle.
   always_comb begin
      wrState_d = wrState_q;
      commit    = 1'b0;
      case (wrState_q)
         WR_IDLE: if (i_wr_en) wrState_d = WR_PEND;
         WR_PEND: if (!i_valid) begin
            commit    = 1'b1;
            wrState_d = WR_IDLE;
         end
         default: wrState_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wrState_q <= WR_IDLE;
         wrIdx_q   <= '0;
         wrRgb_q   <= '0;
      end else begin
         wrState_q <= wrState_d;
         if (wrState_q == WR_IDLE && i_wr_en) begin
            wrIdx_q <= i_wr_idx;
            wrRgb_q <= i_wr_rgb;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < DEPTH; k++) pal_q[k] <= defaultColour(k);
      end else if (commit) begin
         pal_q[wrIdx_q] <= wrRgb_q;
      end
   end

   // Blink phase toggles once every BLINK_FRAMES frame pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frameCnt_q <= '0;
         phase_q    <= 1'b0;
      end else if (i_frame_start) begin
         if (frameCnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            frameCnt_q <= '0;
            phase_q    <= ~phase_q;
         end else begin
            frameCnt_q <= frameCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1Valid_q <= 1'b0;
         s1Dim_q   <= 1'b0;
         s1Blink_q <= 1'b0;
         s1Col_q   <= '0;
         s1Alt_q   <= '0;
      end else begin
         s1Valid_q <= i_valid;
         s1Dim_q   <= i_dim;
         s1Blink_q <= i_blink_mask[i_data];
         s1Col_q   <= pal_q[i_data];
         s1Alt_q   <= pal_q[BLINK_IDX];
      end
   end

   always_comb begin
      s2Sel = (phase_q && s1Blink_q) ? s1Alt_q : s1Col_q;
      rDim  = s2Sel[RGB_W-1 -: COLOR_W];
      gDim  = s2Sel[2*COLOR_W-1 -: COLOR_W];
      bDim  = s2Sel[COLOR_W-1:0];
      if (s1Dim_q) begin
         rDim = rDim >> 1;
         gDim = gDim >> 1;
         bDim = bDim >> 1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         r_q     <= s1Valid_q ? rDim : '0;
         g_q     <= s1Valid_q ? gDim : '0;
         b_q     <= s1Valid_q ? bDim : '0;
         valid_q <= s1Valid_q;
      end
   end

   assign o_VGA_R   = r_q;
   assign o_VGA_G   = g_q;
   assign o_VGA_B   = b_q;
   assign o_valid   = valid_q;
   assign o_wr_busy = (wrState_q == WR_PEND);

endmodule

// File: tb/tb_rgb_palette_lut.sv
// Testbench for rgb_palette_lut: queue scoreboard fed by an independent palette,
// blink and dim model; every pixel cycle is checked two clocks after it is driven.
module tb_rgb_palette_lut;

   localparam int BLINK_FRAMES = 2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  data;
   logic        valid;
   logic        dim;
   logic        frameStart;
   logic [15:0] blinkMask;
   logic        wrEn;
   logic [3:0]  wrIdx;
   logic [23:0] wrRgb;
   logic        wrBusy;
   logic [7:0]  vgaR, vgaG, vgaB;
   logic        oValid;

   logic [23:0] palM [16];
   logic        phaseM;
   int          cntM;
   logic [24:0] sbq [$];
   logic [24:0] expV;
   int          nCompared;
   int          nMismatched;

   rgb_palette_lut #(
      .IDX_W(4), .COLOR_W(8), .BLINK_FRAMES(BLINK_FRAMES), .BLINK_IDX(2)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_dim(dim),
      .i_frame_start(frameStart), .i_blink_mask(blinkMask), .i_wr_en(wrEn),
      .i_wr_idx(wrIdx), .i_wr_rgb(wrRgb), .o_wr_busy(wrBusy),
      .o_VGA_R(vgaR), .o_VGA_G(vgaG), .o_VGA_B(vgaB), .o_valid(oValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [24:0] observed();
      return {oValid, vgaR, vgaG, vgaB};
   endfunction

   task automatic resetModel();
      for (int k = 0; k < 16; k++) palM[k] = 24'hFFFFFF;
      palM[0] = {8'd0,   8'd0,   8'd0};
      palM[1] = {8'd0,   8'd0,   8'd255};
      palM[2] = {8'd255, 8'd255, 8'd255};
      palM[3] = {8'd255, 8'd255, 8'd0};
      palM[4] = {8'd255, 8'd0,   8'd0};
      palM[5] = {8'd255, 8'd204, 8'd255};
      palM[6] = {8'd79,  8'd255, 8'd255};
      palM[7] = {8'd255, 8'd204, 8'd0};
      cntM   = 0;
      phaseM = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] idx, input logic v, input logic d);
      logic [23:0] c;
      data  = idx;
      valid = v;
      dim   = d;
      c = (phaseM && blinkMask[idx]) ? palM[2] : palM[idx];
      if (d) c = {c[23:16] >> 1, c[15:8] >> 1, c[7:0] >> 1};
      if (!v) c = 24'h0;
      sbq.push_back({v, c});
   endtask

   task automatic applyIdle();
      data  = 4'd0;
      valid = 1'b0;
      dim   = 1'b0;
   endtask

   task automatic pulseFrame();
      step();
      frameStart = 1'b1;
      if (cntM == BLINK_FRAMES - 1) begin
         cntM   = 0;
         phaseM = ~phaseM;
      end else begin
         cntM++;
      end
      step();
      frameStart = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(4'd2, 1'b1, 1'b0);
      sbq.delete();
      #3;
      nCompared++;
      if (observed() !== 25'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", observed(), 25'h0);
      end
      repeat (2) @(posedge clk);
      #1;
      nCompared++;
      if (observed() !== 25'h0 || wrBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_held: got %h busy %b expected 0 busy 0", observed(), wrBusy);
      end
      applyIdle();
      @(negedge clk);
      rst_n = 1'b1;
      resetModel();
   endtask

   task automatic test_default_table();
      for (int i = 0; i < 18; i++) begin
         step();
         if (sbq.size() == 2) begin
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL default_table: got %h expected %h", observed(), expV);
            end
         end
         if (i < 16) applyStimulus(4'(i), 1'b1, 1'b0);
         else applyStimulus(4'd3, 1'b0, 1'b0);
      end
      repeat (2) begin
         step();
         expV = sbq.pop_front();
         nCompared++;
         if (observed() !== expV) begin
            nMismatched++;
            $display("[TB] FAIL default_table_drain: got %h expected %h", observed(), expV);
         end
         applyIdle();
      end
   endtask

   task automatic test_dim();
      logic [3:0] idxs [6] = '{4'd4, 4'd6, 4'd5, 4'd2, 4'd2, 4'd7};
      logic       vs   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       ds   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step();
         if (sbq.size() == 2) begin
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL dim: got %h expected %h", observed(), expV);
            end
         end
         applyStimulus(idxs[i], vs[i], ds[i]);
      end
      repeat (2) begin
         step();
         expV = sbq.pop_front();
         nCompared++;
         if (observed() !== expV) begin
            nMismatched++;
            $display("[TB] FAIL dim_drain: got %h expected %h", observed(), expV);
         end
         applyIdle();
      end
   endtask

   task automatic test_blink();
      logic [3:0] idxs [3] = '{4'd1, 4'd3, 4'd1};
      logic       ds   [3] = '{1'b0, 1'b0, 1'b1};
      blinkMask = 16'h0002;
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 3; i++) begin
            step();
            if (sbq.size() == 2) begin
               expV = sbq.pop_front();
               nCompared++;
               if (observed() !== expV) begin
                  nMismatched++;
                  $display("[TB] FAIL blink_frame%0d: got %h expected %h", f, observed(), expV);
               end
            end
            applyStimulus(idxs[i], 1'b1, ds[i]);
         end
         repeat (2) begin
            step();
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL blink_drain%0d: got %h expected %h", f, observed(), expV);
            end
            applyIdle();
         end
         pulseFrame();
      end
      blinkMask = 16'h0000;
   endtask

   task automatic test_write();
      step();
      applyStimulus(4'd0, 1'b1, 1'b0);
      wrEn = 1'b1; wrIdx = 4'd1; wrRgb = {8'd10, 8'd20, 8'd30};
      step();
      nCompared++;
      if (wrBusy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL write_busy_set: got %b expected 1", wrBusy);
      end
      wrEn = 1'b1; wrIdx = 4'd1; wrRgb = 24'h636363;
      applyStimulus(4'd7, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         if (sbq.size() == 2) begin
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL write_active_pixel: got %h expected %h", observed(), expV);
            end
         end
         nCompared++;
         if (wrBusy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL write_busy_hold: got %b expected 1", wrBusy);
         end
         wrEn = 1'b0;
         if (i == 0) applyStimulus(4'd1, 1'b1, 1'b0);
         else applyStimulus(4'd0, 1'b0, 1'b0);
      end
      step();
      expV = sbq.pop_front();
      nCompared++;
      if (observed() !== expV) begin
         nMismatched++;
         $display("[TB] FAIL write_commit_pixel: got %h expected %h", observed(), expV);
      end
      nCompared++;
      if (wrBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL write_busy_clear: got %b expected 0", wrBusy);
      end
      palM[1] = {8'd10, 8'd20, 8'd30};
      applyStimulus(4'd1, 1'b1, 1'b0);
      step();
      expV = sbq.pop_front();
      nCompared++;
      if (observed() !== expV) begin
         nMismatched++;
         $display("[TB] FAIL write_pre_pixel: got %h expected %h", observed(), expV);
      end
      applyStimulus(4'd1, 1'b1, 1'b1);
      repeat (2) begin
         step();
         expV = sbq.pop_front();
         nCompared++;
         if (observed() !== expV) begin
            nMismatched++;
            $display("[TB] FAIL write_new_value: got %h expected %h", observed(), expV);
         end
         applyIdle();
      end
      // Request made while blanking still passes through the pending state.
      wrEn = 1'b1; wrIdx = 4'd9; wrRgb = 24'h123456;
      step();
      nCompared++;
      if (wrBusy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL write_blank_busy: got %b expected 1", wrBusy);
      end
      wrEn = 1'b0;
      step();
      nCompared++;
      if (wrBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL write_blank_commit: got %b expected 0", wrBusy);
      end
      palM[9] = 24'h123456;
      applyStimulus(4'd9, 1'b1, 1'b0);
      step();
      applyIdle();
      step();
      expV = sbq.pop_front();
      nCompared++;
      if (observed() !== expV) begin
         nMismatched++;
         $display("[TB] FAIL write_blank_value: got %h expected %h", observed(), expV);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] idxs [3] = '{4'd0, 4'd0, 4'd1};
      logic       vs   [3] = '{1'b0, 1'b0, 1'b1};
      step();
      applyStimulus(4'd3, 1'b1, 1'b0);
      wrEn = 1'b1; wrIdx = 4'd1; wrRgb = 24'hABCDEF;
      step();
      wrEn = 1'b0;
      applyStimulus(4'd3, 1'b1, 1'b0);
      step();
      nCompared++;
      if (wrBusy !== 1'b1 || observed() !== {1'b1, 24'hFFFF00}) begin
         nMismatched++;
         $display("[TB] FAIL reset_mid_pre: got %h busy %b expected %h busy 1",
                  observed(), wrBusy, {1'b1, 24'hFFFF00});
      end
      #3;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (observed() !== 25'h0 || wrBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_mid_async: got %h busy %b expected 0 busy 0", observed(), wrBusy);
      end
      sbq.delete();
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (sbq.size() == 2) begin
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL reset_mid_after: got %h expected %h", observed(), expV);
            end
         end
         applyStimulus(idxs[i], vs[i], 1'b0);
      end
      repeat (2) begin
         step();
         expV = sbq.pop_front();
         nCompared++;
         if (observed() !== expV) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_blue: got %h expected %h", observed(), expV);
         end
         nCompared++;
         if (wrBusy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_busy: got %b expected 0", wrBusy);
         end
         applyIdle();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 1000; i++) begin
         step();
         if (sbq.size() == 2) begin
            expV = sbq.pop_front();
            nCompared++;
            if (observed() !== expV) begin
               nMismatched++;
               $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, observed(), expV);
            end
         end
         applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
                       1'($urandom_range(0, 1)));
      end
      repeat (2) begin
         step();
         expV = sbq.pop_front();
         nCompared++;
         if (observed() !== expV) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_drain: got %h expected %h", observed(), expV);
         end
         applyIdle();
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      data = '0; valid = 1'b0; dim = 1'b0; frameStart = 1'b0;
      blinkMask = '0; wrEn = 1'b0; wrIdx = '0; wrRgb = '0;
      resetModel();
      test_reset();
      test_default_table();
      test_dim();
      test_blink();
      test_write();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
